// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection phase scheduler: lamp encodings,
// controller state codes and round-robin requester indices.
package intersection_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    GREEN_A  = 3'd0,
    YELLOW_A = 3'd1,
    GREEN_B  = 3'd2,
    YELLOW_B = 3'd3,
    WALK     = 3'd4,
    ALL_RED  = 3'd5
  } phase_e;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_A    = 2'd0;
  localparam req_idx_t REQ_B    = 2'd1;
  localparam req_idx_t REQ_WALK = 2'd2;

  // Next requester in the fixed A -> B -> WALK -> A rotation.
  function automatic req_idx_t req_next(input req_idx_t idx);
    return (idx == REQ_WALK) ? REQ_A : req_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Request and lamp signals of the intersection phase scheduler.
// EMERGENCY_PREEMPT_EN adds the emergency pre-emption inputs.
interface intersection_phase_scheduler_if;
  logic       traffic_A;
  logic       traffic_B;
  logic       ped_req;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req;
  logic       emerg_dir;

  modport master (output traffic_A, traffic_B, ped_req, emerg_req, emerg_dir,
                  input  LA, LB, walk, ped_ack, phase);
  modport slave  (input  traffic_A, traffic_B, ped_req, emerg_req, emerg_dir,
                  output LA, LB, walk, ped_ack, phase);
`else
  modport master (output traffic_A, traffic_B, ped_req,
                  input  LA, LB, walk, ped_ack, phase);
  modport slave  (input  traffic_A, traffic_B, ped_req,
                  output LA, LB, walk, ped_ack, phase);
`endif
endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Per-phase cycle timer: cleared on state entry, saturating increment.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic [TW-1:0] count
);

  localparam logic [TW-1:0] SAT = '1;

  // Count cycles spent in the current phase, holding at the top value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection plus pedestrian crossing phase scheduler.
// Round-robin arbitration between A, B and WALK after every all-red clearance.
// Optional feature macro: EMERGENCY_PREEMPT_EN (emergency vehicle pre-emption).
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN    = 8,
  parameter int MAX_GREEN    = 32,
  parameter int YELLOW_TIME  = 5,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 10,
  parameter int TW           = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  intersection_phase_scheduler_if.slave  bus
);

  localparam logic [TW-1:0] MIN_LAST  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);

  phase_e        state, state_next;
  req_idx_t      last_served, last_next;
  logic [TW-1:0] timer;
  logic          ped_pending;
  logic          ped_ack;
  logic          walk_entry;
  logic          green_a_end, green_b_end, walk_end;
  logic [2:0]    reqs;
  req_idx_t      cand1, cand2, pick;
  logic [1:0]    la, lb;
  logic          walk;

  function automatic logic req_on(input logic [2:0] r, input req_idx_t idx);
    case (idx)
      REQ_A:    return r[0];
      REQ_B:    return r[1];
      REQ_WALK: return r[2];
      default:  return 1'b0;
    endcase
  endfunction

  function automatic phase_e phase_for(input req_idx_t idx);
    case (idx)
      REQ_B:    return GREEN_B;
      REQ_WALK: return WALK;
      default:  return GREEN_A;
    endcase
  endfunction

  phase_timer #(.TW(TW)) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_next != state),
    .count   (timer)
  );

  // Phase-end conditions and round-robin candidate selection.
  always_comb begin
    reqs        = {ped_pending, bus.traffic_B, bus.traffic_A};
    green_a_end = (timer >= MIN_LAST) && (bus.traffic_B || ped_pending) &&
                  (!bus.traffic_A || (timer >= MAX_LAST));
    green_b_end = (timer >= MIN_LAST) && (bus.traffic_A || ped_pending) &&
                  (!bus.traffic_B || (timer >= MAX_LAST));
    walk_end    = (timer == WALK_LAST);
`ifdef EMERGENCY_PREEMPT_EN
    // Emergency: clear the crossing road at once, hold the emergency road.
    if (bus.emerg_req) begin
      green_a_end = bus.emerg_dir;
      green_b_end = !bus.emerg_dir;
      walk_end    = 1'b1;
    end
`endif
    cand1 = req_next(last_served);
    cand2 = req_next(cand1);
    if (req_on(reqs, cand1))            pick = cand1;
    else if (req_on(reqs, cand2))       pick = cand2;
    else if (req_on(reqs, last_served)) pick = last_served;
    else                                pick = REQ_A;
  end

  // Next-state and last-served selection.
  always_comb begin
    state_next = state;
    last_next  = last_served;
    case (state)
      GREEN_A:  if (green_a_end) state_next = YELLOW_A;
      YELLOW_A: if (timer == YEL_LAST) state_next = ALL_RED;
      GREEN_B:  if (green_b_end) state_next = YELLOW_B;
      YELLOW_B: if (timer == YEL_LAST) state_next = ALL_RED;
      WALK:     if (walk_end) state_next = ALL_RED;
      ALL_RED: begin
        if (timer == AR_LAST) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (bus.emerg_req) begin
            state_next = bus.emerg_dir ? GREEN_B : GREEN_A;
          end else begin
            state_next = phase_for(pick);
            last_next  = pick;
          end
`else
          state_next = phase_for(pick);
          last_next  = pick;
`endif
        end
      end
      default:  state_next = ALL_RED;
    endcase
  end

  assign walk_entry = (state_next == WALK) && (state != WALK);

  // State, arbitration history, pedestrian latch and acknowledge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= GREEN_A;
      last_served <= REQ_A;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      state       <= state_next;
      last_served <= last_next;
      ped_ack     <= walk_entry;
      if (walk_entry)       ped_pending <= 1'b0;
      else if (bus.ped_req) ped_pending <= 1'b1;
    end
  end

  // Moore lamp decode; anything not named drives all lamps red.
  always_comb begin
    la   = LIGHT_RED;
    lb   = LIGHT_RED;
    walk = 1'b0;
    case (state)
      GREEN_A:  la   = LIGHT_GREEN;
      YELLOW_A: la   = LIGHT_YELLOW;
      GREEN_B:  lb   = LIGHT_GREEN;
      YELLOW_B: lb   = LIGHT_YELLOW;
      WALK:     walk = 1'b1;
      default:  ;
    endcase
  end

  assign bus.LA      = la;
  assign bus.LB      = lb;
  assign bus.walk    = walk;
  assign bus.ped_ack = ped_ack;
  assign bus.phase   = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: stimulus pushes the
// expected phase transitions (phase, lamps, ack, cycle since reset release);
// the monitor pops and compares on every observed phase change.
// EMERGENCY_PREEMPT_EN enables the pre-emption scenario.
module tb_intersection_phase_scheduler;
  import intersection_pkg::*;

  typedef struct packed {
    logic [2:0]  phase;
    logic [1:0]  la;
    logic [1:0]  lb;
    logic        walk;
    logic        ack;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          ack_seen = 0;
  logic [2:0]  prev_phase = 3'd0;
  exp_t        exp_q[$];
  exp_t        e;
  exp_t        act;

  always #5 clk = ~clk;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input int unsigned actual, input int unsigned required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic expect_phase(input phase_e p, input int unsigned c);
    exp_t x;
    x.phase = p;
    x.la    = LIGHT_RED;
    x.lb    = LIGHT_RED;
    x.walk  = 1'b0;
    x.ack   = 1'b0;
    x.cyc   = c;
    case (p)
      GREEN_A:  x.la = LIGHT_GREEN;
      YELLOW_A: x.la = LIGHT_YELLOW;
      GREEN_B:  x.lb = LIGHT_GREEN;
      YELLOW_B: x.lb = LIGHT_YELLOW;
      WALK: begin x.walk = 1'b1; x.ack = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(x);
  endtask

  // Monitor: sample after each rising edge, compare on every phase change.
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      cyc        = 0;
      prev_phase = bus.phase;
    end else begin
      cyc++;
      if (bus.ped_ack === 1'b1) ack_seen++;
      if (bus.phase !== prev_phase) begin
        n_checks++;
        act = '{bus.phase, bus.LA, bus.LB, bus.walk, bus.ped_ack, cyc};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_transition: phase %0d at cycle %0d, expected no change",
                   bus.phase, cyc);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL transition: got phase=%0d LA=%b LB=%b walk=%b ack=%b cyc=%0d, expected phase=%0d LA=%b LB=%b walk=%b ack=%b cyc=%0d",
                     act.phase, act.la, act.lb, act.walk, act.ack, act.cyc,
                     e.phase, e.la, e.lb, e.walk, e.ack, e.cyc);
          end
        end
        prev_phase = bus.phase;
      end
    end
  end

  task automatic clear_inputs();
    bus.traffic_A = 1'b0;
    bus.traffic_B = 1'b0;
    bus.ped_req   = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    bus.emerg_req = 1'b0;
    bus.emerg_dir = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Move to the falling edge after rising edge number c (counted from release).
  task automatic wait_cyc(input int unsigned c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < c) chk("wait_cyc_timeout", cyc, c);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_base;
    clear_inputs();

    // Reset values and idle rest in GREEN_A.
    repeat (3) @(negedge clk);
    chk("rst_LA", bus.LA, LIGHT_GREEN);
    chk("rst_LB", bus.LB, LIGHT_RED);
    chk("rst_walk", bus.walk, 0);
    chk("rst_ped_ack", bus.ped_ack, 0);
    chk("rst_phase", bus.phase, GREEN_A);
    reset_n = 1'b1;
    wait_cyc(100);
    chk("idle_phase", bus.phase, GREEN_A);
    chk("idle_LA", bus.LA, LIGHT_GREEN);
    chk("idle_LB", bus.LB, LIGHT_RED);

    // Both roads loaded: max-green termination and alternation.
    do_reset();
    bus.traffic_A = 1'b1;
    bus.traffic_B = 1'b1;
    expect_phase(YELLOW_A, 32);
    expect_phase(ALL_RED, 37);
    expect_phase(GREEN_B, 39);
    expect_phase(YELLOW_B, 71);
    expect_phase(ALL_RED, 76);
    expect_phase(GREEN_A, 78);
    drain(200);

    // B demand from cycle 3 ends green at MIN_GREEN; then pedestrian wins RR.
    do_reset();
    expect_phase(YELLOW_A, 8);
    expect_phase(ALL_RED, 13);
    expect_phase(GREEN_B, 15);
    expect_phase(YELLOW_B, 23);
    expect_phase(ALL_RED, 28);
    expect_phase(WALK, 30);
    expect_phase(ALL_RED, 40);
    expect_phase(GREEN_A, 42);
    wait_cyc(3);
    bus.traffic_B = 1'b1;
    wait_cyc(20);
    ack_base = ack_seen;
    bus.traffic_A = 1'b1;
    bus.traffic_B = 1'b0;
    bus.ped_req   = 1'b1;
    @(negedge clk);
    bus.ped_req   = 1'b0;
    drain(100);
    wait_cyc(60);
    chk("ped_ack_pulses", ack_seen - ack_base, 1);
    chk("after_walk_phase", bus.phase, GREEN_A);

    // Asynchronous reset in the middle of YELLOW_B.
    do_reset();
    expect_phase(YELLOW_A, 8);
    expect_phase(ALL_RED, 13);
    expect_phase(GREEN_B, 15);
    expect_phase(YELLOW_B, 23);
    wait_cyc(3);
    bus.traffic_B = 1'b1;
    wait_cyc(20);
    bus.traffic_A = 1'b1;
    bus.traffic_B = 1'b0;
    drain(50);
    wait_cyc(25);
    chk("pre_reset_LB", bus.LB, LIGHT_YELLOW);
    reset_n = 1'b0;
    #1;
    chk("midrst_LA", bus.LA, LIGHT_GREEN);
    chk("midrst_LB", bus.LB, LIGHT_RED);
    chk("midrst_phase", bus.phase, GREEN_A);
    chk("midrst_walk", bus.walk, 0);
    chk("midrst_ped_ack", bus.ped_ack, 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency towards B at GREEN_A timer 2; B held until the request drops.
    do_reset();
    expect_phase(YELLOW_A, 3);
    expect_phase(ALL_RED, 8);
    expect_phase(GREEN_B, 10);
    expect_phase(YELLOW_B, 61);
    expect_phase(ALL_RED, 66);
    expect_phase(GREEN_A, 68);
    wait_cyc(2);
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 1'b1;
    bus.traffic_A = 1'b1;
    wait_cyc(60);
    bus.emerg_req = 1'b0;
    drain(100);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

- Sequences a two-road intersection (Academic Ave = A, Bravado Blvd = B) plus a pedestrian crossing.
- Arbitrates the shared junction between three requesters (A traffic, B traffic, pedestrian walk) using round-robin after every all-red clearance.
- Enforces minimum/maximum green, yellow and all-red intervals in clock cycles.
- Its light outputs drive the lamp drivers directly.

## Interface
- MIN_GREEN, 8: minimum green cycles before a green may end.
- MAX_GREEN, 32: green cycles after which the phase ends if another request is pending.
- YELLOW_TIME, 5: yellow cycles.
- ALL_RED_TIME, 2: all-red clearance cycles.
- WALK_TIME, 10: walk cycles.
- TW, 8: timer width; all time parameters must be ≥1 and <2^TW.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- traffic_A  in  1  level; vehicle demand on A.
- traffic_B  in  1  level; vehicle demand on B.
- ped_req  in  1  single-cycle pedestrian button pulse.
- LA  out  2  A lamp: 00 red, 01 yellow, 10 green.
- LB  out  2  B lamp, same encoding.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse on entry to WALK.
- phase  out  3  current state code, for debug.

## Operation
- States: GREEN_A, YELLOW_A, GREEN_B, YELLOW_B, WALK, ALL_RED.
- The cycle timer clears on every state entry and increments every cycle. It saturates at 2^TW−1.
- Lamps are Moore-decoded from the state. Any state not named below drives all lamps red.
  - GREEN_A: LA=10. YELLOW_A: LA=01.
  - GREEN_B: LB=10. YELLOW_B: LB=01.
  - WALK: walk=1.
- ped_pending sets on ped_req and clears on WALK entry. If both occur in the same cycle, the clear wins.
- "Other pending" for GREEN_A means traffic_B | ped_pending. For GREEN_B it means traffic_A | ped_pending.
- GREEN_X → YELLOW_X when timer ≥ MIN_GREEN−1, other pending is true, and either traffic_X==0 or timer ≥ MAX_GREEN−1.
  - With no other request pending, GREEN_X holds indefinitely.
- YELLOW_X → ALL_RED when timer == YELLOW_TIME−1.
- WALK → ALL_RED when timer == WALK_TIME−1.
- ALL_RED exits when timer == ALL_RED_TIME−1. The next phase is chosen by round-robin:
  - Priority order starts after last_served and cycles A → B → WALK.
  - Requests are A=traffic_A, B=traffic_B, WALK=ped_pending.
  - With no request pending, go to GREEN_A (rest).
  - Update last_served on this exit.
- Reset values: state GREEN_A, timer 0, last_served=A, ped_pending 0, LA=10, LB=00, walk=0, ped_ack=0, phase=GREEN_A code.
- Reset is honoured mid-phase, including during YELLOW or WALK, with no clearance interval.

## Timing
- Lamp outputs change in the same cycle that the state register updates; there is no extra output register.
- ped_req sampled at edge k gives ped_pending=1 after edge k.
- Minimum path from GREEN_A to GREEN_B: MIN_GREEN green + YELLOW_TIME + ALL_RED_TIME cycles.
- traffic inputs are assumed synchronous to clk. Synchronizers live upstream.

## Configuration
- EMERGENCY_PREEMPT_EN defined:
  - Adds ports emerg_req (in, 1, level) and emerg_dir (in, 1; 0=A, 1=B).
  - While emerg_req=1, a GREEN on the non-emerg_dir road goes to its YELLOW on the next edge, ignoring MIN_GREEN.
  - WALK goes to ALL_RED on the next edge.
  - ALL_RED selects GREEN of emerg_dir regardless of round-robin, and last_served is not updated.
  - GREEN of emerg_dir holds while emerg_req=1.
  - ped_pending is preserved throughout.
- Undefined: these ports and this logic are absent, and behaviour is exactly as in Operation.

## Structure
- intersection_pkg holds:
  - Lamp encodings LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN.
  - The state enum and its 3-bit codes.
  - Requester index constants REQ_A/REQ_B/REQ_WALK.
- One sub-module, phase_timer: TW-bit counter with a synchronous clear on state entry, saturating increment, and async active-low reset.

## Test plan
- Reset release with no demand: stays GREEN_A, LA=10, LB=00 for 100 cycles.
- traffic_A=1, traffic_B=1 held: GREEN_A lasts MAX_GREEN (32) cycles, then YELLOW_A for 5, ALL_RED for 2, then GREEN_B.
- traffic_A=0, traffic_B pulse at cycle 3: YELLOW_A is entered only after timer reaches 7 (MIN_GREEN).
- ped_req during GREEN_B with traffic_A=1 and last_served=B: after ALL_RED the next phase is WALK.
  - ped_ack pulses once, walk=1 for 10 cycles, then ALL_RED, then GREEN_A.
- reset_n asserted mid-YELLOW_B: outputs return immediately to reset values (LA=10, LB=00).
- With EMERGENCY_PREEMPT_EN: emerg_req=1, emerg_dir=1 at GREEN_A timer=2 → YELLOW_A next cycle → ALL_RED → GREEN_B held until emerg_req falls.
